// File: rtl/bp_table_ctrl.sv
// Port sequencer for the branch-predictor 2-bit counter table: init clear, lookup/update arbitration, RMW.
// Optional statistics counters are enabled with `define BP_CTRL_STATS_EN.
module bp_table_ctrl #(
    parameter int TAG_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             in_fetch_valid,
    input  logic [TAG_W-1:0] in_fetch_tag,
    output logic             out_fetch_ready,
    output logic             out_fetch_resp_valid,
    output logic             out_fetch_jump,
    input  logic             in_rob_bp_ce,
    input  logic [TAG_W-1:0] in_rob_tag,
    input  logic             in_rob_jump,
    output logic             out_rob_bp_full,
    output logic [TAG_W-1:0] out_tbl_addr,
    output logic             out_tbl_we,
    output logic [1:0]       out_tbl_wdata,
    input  logic [1:0]       in_tbl_rdata
`ifdef BP_CTRL_STATS_EN
    ,
    output logic [31:0]      out_stat_lookups,
    output logic [31:0]      out_stat_updates,
    output logic [31:0]      out_stat_drops
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    typedef enum logic [1:0] {INIT, IDLE, UPD_WR} state_e;

    state_e           state_q, state_d;
    logic [TAG_W-1:0] init_q, init_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             resp_q, resp_d;

    logic [TAG_W-1:0]      tag_mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] jmp_mem_q;
    logic [PW:0]           wr_ptr_q, rd_ptr_q;

    logic             fifo_empty, fifo_full;
    logic             push, pop;
    logic             update_sel, fetch_grant;
    logic [TAG_W-1:0] head_tag;
    logic             head_jmp;
    logic [1:0]       upd_wdata;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                        (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign push       = rdy && in_rob_bp_ce && !fifo_full;
    assign head_tag   = tag_mem_q[rd_ptr_q[PW-1:0]];
    assign head_jmp   = jmp_mem_q[rd_ptr_q[PW-1:0]];

    assign update_sel = !fifo_empty &&
                        (fifo_full || starve_q == SMAX || !in_fetch_valid);

    always_comb begin
        if (head_jmp)
            upd_wdata = (in_tbl_rdata == 2'b11) ? 2'b11 : in_tbl_rdata + 2'b01;
        else
            upd_wdata = (in_tbl_rdata == 2'b00) ? 2'b00 : in_tbl_rdata - 2'b01;
    end

    assign out_rob_bp_full      = fifo_full;
    assign out_fetch_resp_valid = resp_q;
    assign out_fetch_jump       = resp_q & in_tbl_rdata[1];

    // Address is kept steady while rdy is low so the RAM keeps re-reading
    // the same entry and the stalled RMW still sees the right value.
    always_comb begin
        state_d         = state_q;
        init_d          = init_q;
        starve_d        = starve_q;
        resp_d          = resp_q;
        pop             = 1'b0;
        fetch_grant     = 1'b0;
        out_fetch_ready = 1'b0;
        out_tbl_addr    = '0;
        out_tbl_we      = 1'b0;
        out_tbl_wdata   = 2'b00;
        if (!rst) begin
            if (rdy)
                resp_d = 1'b0;
            unique case (state_q)
                INIT: begin
                    out_tbl_addr  = init_q;
                    out_tbl_wdata = 2'b01;
                    out_tbl_we    = rdy;
                    if (rdy) begin
                        init_d = init_q + 1'b1;
                        if (&init_q)
                            state_d = IDLE;
                    end
                end
                IDLE: begin
                    if (update_sel) begin
                        out_tbl_addr = head_tag;
                        if (rdy) begin
                            state_d  = UPD_WR;
                            starve_d = '0;
                        end
                    end else begin
                        out_fetch_ready = rdy;
                        if (in_fetch_valid)
                            out_tbl_addr = in_fetch_tag;
                        fetch_grant = rdy && in_fetch_valid;
                        if (fetch_grant)
                            resp_d = 1'b1;
                        if (rdy) begin
                            if (fifo_empty)
                                starve_d = '0;
                            else if (fetch_grant && starve_q != SMAX)
                                starve_d = starve_q + 1'b1;
                        end
                    end
                end
                UPD_WR: begin
                    out_tbl_addr  = head_tag;
                    out_tbl_wdata = upd_wdata;
                    out_tbl_we    = rdy;
                    if (rdy) begin
                        pop     = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= INIT;
            init_q   <= '0;
            starve_q <= '0;
            resp_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            init_q   <= init_d;
            starve_q <= starve_d;
            resp_q   <= resp_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            tag_mem_q[wr_ptr_q[PW-1:0]] <= in_rob_tag;
            jmp_mem_q[wr_ptr_q[PW-1:0]] <= in_rob_jump;
        end
    end

`ifdef BP_CTRL_STATS_EN
    logic        drop;
    logic [31:0] lookups_q, updates_q, drops_q;

    assign drop = rdy && in_rob_bp_ce && fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            lookups_q <= '0;
            updates_q <= '0;
            drops_q   <= '0;
        end else begin
            if (fetch_grant)
                lookups_q <= lookups_q + 32'd1;
            if (pop)
                updates_q <= updates_q + 32'd1;
            if (drop)
                drops_q <= drops_q + 32'd1;
        end
    end

    assign out_stat_lookups = lookups_q;
    assign out_stat_updates = updates_q;
    assign out_stat_drops   = drops_q;
`endif

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Scoreboard bench for bp_table_ctrl with a behavioural write-then-read table RAM.
// Optional statistics ports are checked when BP_CTRL_STATS_EN is defined.
module tb_bp_table_ctrl;

    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst, rdy;
    logic          in_fetch_valid;
    logic [TW-1:0] in_fetch_tag;
    logic          out_fetch_ready, out_fetch_resp_valid, out_fetch_jump;
    logic          in_rob_bp_ce;
    logic [TW-1:0] in_rob_tag;
    logic          in_rob_jump;
    logic          out_rob_bp_full;
    logic [TW-1:0] out_tbl_addr;
    logic          out_tbl_we;
    logic [1:0]    out_tbl_wdata;
    logic [1:0]    in_tbl_rdata;
`ifdef BP_CTRL_STATS_EN
    logic [31:0]   out_stat_lookups, out_stat_updates, out_stat_drops;
`endif

    bp_table_ctrl #(.TAG_W(TW), .FIFO_DEPTH(4), .STARVE_MAX(4)) dut (
        .clk(clk),
        .rst(rst),
        .rdy(rdy),
        .in_fetch_valid(in_fetch_valid),
        .in_fetch_tag(in_fetch_tag),
        .out_fetch_ready(out_fetch_ready),
        .out_fetch_resp_valid(out_fetch_resp_valid),
        .out_fetch_jump(out_fetch_jump),
        .in_rob_bp_ce(in_rob_bp_ce),
        .in_rob_tag(in_rob_tag),
        .in_rob_jump(in_rob_jump),
        .out_rob_bp_full(out_rob_bp_full),
        .out_tbl_addr(out_tbl_addr),
        .out_tbl_we(out_tbl_we),
        .out_tbl_wdata(out_tbl_wdata),
        .in_tbl_rdata(in_tbl_rdata)
`ifdef BP_CTRL_STATS_EN
        ,
        .out_stat_lookups(out_stat_lookups),
        .out_stat_updates(out_stat_updates),
        .out_stat_drops(out_stat_drops)
`endif
    );

    always #5 clk = ~clk;

    logic [1:0] mem [16];
    always @(posedge clk) begin
        if (out_tbl_we)
            mem[out_tbl_addr] <= out_tbl_wdata;
        in_tbl_rdata <= out_tbl_we ? out_tbl_wdata : mem[out_tbl_addr];
    end

    int n_pass = 0;
    int n_total = 0;
    logic [5:0] wq [$];
    logic       rq [$];
    logic [5:0] w_exp;
    logic       r_exp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && out_tbl_we) begin
            if (wq.size() == 0) begin
                n_total++;
                $display("FAIL unexp_write: got addr %0d data %0d, required no write",
                         out_tbl_addr, out_tbl_wdata);
            end else begin
                w_exp = wq.pop_front();
                chk("tbl_write", {26'd0, out_tbl_addr, out_tbl_wdata}, {26'd0, w_exp});
            end
        end
        if (!rst && out_fetch_resp_valid) begin
            if (rq.size() == 0) begin
                n_total++;
                $display("FAIL unexp_resp: got jump %0d, required no response", out_fetch_jump);
            end else begin
                r_exp = rq.pop_front();
                chk("fetch_jump", 32'(out_fetch_jump), 32'(r_exp));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_init();
        for (int i = 0; i < 16; i++)
            wq.push_back({4'(i), 2'b01});
    endtask

    logic [0:8]  exp_starve;
    logic [0:24] exp_full;
    logic [3:0]  ftags [5];

    initial begin
        rst = 1'b1; rdy = 1'b1;
        in_fetch_valid = 1'b0; in_fetch_tag = '0;
        in_rob_bp_ce = 1'b0; in_rob_tag = '0; in_rob_jump = 1'b0;
        exp_starve = 9'b111110011;
        exp_full   = 25'b1111001111001111001111001;
        ftags[0] = 4'd1; ftags[1] = 4'd2; ftags[2] = 4'd4;
        ftags[3] = 4'd6; ftags[4] = 4'd7;

        push_init();
        step();
        @(negedge clk);
        chk("rst_ready", 32'(out_fetch_ready), 32'd0);
        chk("rst_resp", 32'(out_fetch_resp_valid), 32'd0);
        chk("rst_jump", 32'(out_fetch_jump), 32'd0);
        chk("rst_full", 32'(out_rob_bp_full), 32'd0);
        chk("rst_tbl", {25'd0, out_tbl_we, out_tbl_addr, out_tbl_wdata}, 32'd0);
        step();
        rst = 1'b0;

        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            chk("init_ready", 32'(out_fetch_ready), 32'(i == 16));
            if (i < 16)
                step();
        end
        in_fetch_valid = 1'b1; in_fetch_tag = 4'd5;
        rq.push_back(1'b0);
        step();
        in_fetch_valid = 1'b0;
        repeat (2) step();

        in_rob_bp_ce = 1'b1; in_rob_tag = 4'd3; in_rob_jump = 1'b1;
        wq.push_back({4'd3, 2'd2});
        step();
        wq.push_back({4'd3, 2'd3});
        step();
        in_rob_bp_ce = 1'b0;
        repeat (4) step();
        in_fetch_valid = 1'b1; in_fetch_tag = 4'd3;
        rq.push_back(1'b1);
        step();
        in_fetch_valid = 1'b0;
        in_rob_bp_ce = 1'b1;
        wq.push_back({4'd3, 2'd3});
        step();
        in_rob_bp_ce = 1'b0;
        repeat (4) step();

        in_fetch_valid = 1'b1; in_fetch_tag = 4'd9;
        in_rob_bp_ce = 1'b1; in_rob_tag = 4'd10; in_rob_jump = 1'b0;
        wq.push_back({4'd10, 2'd0});
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("starve_ready", 32'(out_fetch_ready), 32'(exp_starve[i]));
            if (exp_starve[i])
                rq.push_back(1'b0);
            step();
            in_rob_bp_ce = 1'b0;
        end
        in_fetch_valid = 1'b0;
        repeat (2) step();

        in_fetch_valid = 1'b1; in_fetch_tag = 4'd9;
        for (int i = 0; i < 4; i++)
            wq.push_back({ftags[i], 2'd2});
        for (int i = 0; i < 25; i++) begin
            in_rob_bp_ce = (i < 5);
            in_rob_tag   = (i < 5) ? ftags[i] : 4'd0;
            in_rob_jump  = 1'b1;
            @(negedge clk);
            chk("full_ready", 32'(out_fetch_ready), 32'(exp_full[i]));
            if (exp_full[i])
                rq.push_back(1'b0);
            if (i == 3)
                chk("full_before", 32'(out_rob_bp_full), 32'd0);
            if (i == 4)
                chk("full_after4", 32'(out_rob_bp_full), 32'd1);
            step();
        end
        in_fetch_valid = 1'b0; in_rob_bp_ce = 1'b0;
`ifdef BP_CTRL_STATS_EN
        chk("stat_drops", out_stat_drops, 32'd1);
`endif
        repeat (2) step();

        in_rob_bp_ce = 1'b1; in_rob_tag = 4'd11; in_rob_jump = 1'b1;
        wq.push_back({4'd11, 2'd2});
        step();
        in_rob_bp_ce = 1'b0;
        step();
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_rob_bp_ce = (k == 1); in_rob_tag = 4'd13;
            @(negedge clk);
            chk("stall_we", 32'(out_tbl_we), 32'd0);
            chk("stall_ready", 32'(out_fetch_ready), 32'd0);
            step();
        end
        in_rob_bp_ce = 1'b0;
        rdy = 1'b1;
        @(negedge clk);
        chk("stall_release_we", 32'(out_tbl_we), 32'd1);
        repeat (3) step();

        in_rob_bp_ce = 1'b1; in_rob_tag = 4'd12; in_rob_jump = 1'b1;
        step();
        in_rob_bp_ce = 1'b0;
        step();
        rst = 1'b1;
        push_init();
        @(negedge clk);
        chk("rst_upd_we", 32'(out_tbl_we), 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i <= 17; i++) begin
            @(negedge clk);
            chk("reinit_ready", 32'(out_fetch_ready), 32'(i >= 16));
            if (i < 17)
                step();
        end
        in_fetch_valid = 1'b1; in_fetch_tag = 4'd12;
        rq.push_back(1'b0);
        step();
        in_fetch_valid = 1'b0;
        repeat (4) step();

        chk("writes_left", 32'(wq.size()), 32'd0);
        chk("resps_left", 32'(rq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
